// File: rtl/rgb_mem_pkg.sv
// Shared definitions for the R/G/B frame-memory arbiter.
// Holds the image and memory geometry, the client and channel identifiers,
// the read-return tag type and a one-hot helper.
package rgb_mem_pkg;

    localparam int ADDR_W = 14;   // row = addr[13:7], col = addr[6:0]
    localparam int DATA_W = 8;    // per-channel pixel width
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;

    localparam logic CLI_DEMOSAIC = 1'b0;
    localparam logic CLI_HOST     = 1'b1;

    // Bit / lane positions inside the {r,g,b} write-enable and data groups
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // One stage of the read-return tracking pipeline
    typedef struct packed {
        logic valid;
        logic client;
    } rd_tag_t;

    function automatic logic [1:0] onehot2(input logic idx);
        onehot2 = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin arbiter with a bounded burst lock.
// The current owner keeps the grant while it requests, unless it has already
// held MAX_BURST consecutive grants and the other client is waiting.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   req [1:0]   per-client request
//   gnt [1:0]   combinational one-hot grant (subset of req)
//   winner      index of the client that wins this cycle
//   hs          a command is accepted this cycle
module rr_arb2
    import rgb_mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       winner,
    output logic       hs
);

    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    arb_state_e       state;
    logic             owner;
    logic             rr_last;
    logic [CNT_W-1:0] burst_cnt;
    logic             keep;

    // Winner selection: burst lock first, then lone requester, then round robin
    always_comb begin
        keep   = 1'b0;
        winner = ~rr_last;
        if ((state == ARB_BUSY) && req[owner] &&
            !((burst_cnt == CNT_MAX) && req[~owner])) begin
            keep = 1'b1;
        end else begin
            keep = 1'b0;
        end
        if (keep) begin
            winner = owner;
        end else begin
            case (req)
                2'b01:   winner = CLI_DEMOSAIC;
                2'b10:   winner = CLI_HOST;
                default: winner = ~rr_last;
            endcase
        end
        gnt = onehot2(winner) & req;
        hs  = |gnt;
    end

    // Ownership, round-robin pointer and burst counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= CLI_DEMOSAIC;
            rr_last   <= CLI_HOST;
            burst_cnt <= {CNT_W{1'b0}};
        end else if (hs) begin
            state   <= ARB_BUSY;
            owner   <= winner;
            rr_last <= winner;
            if ((state == ARB_BUSY) && (winner == owner)) begin
                // Saturate so a lone owner keeps the grant indefinitely
                burst_cnt <= (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + CNT_ONE;
            end else begin
                burst_cnt <= CNT_ONE;
            end
        end else begin
            state     <= ARB_IDLE;
            burst_cnt <= {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/rgb_mem_arbiter.sv
// Shares the single-port R/G/B frame memories between the demosaic engine
// (client 0) and the readout/host port (client 1).
// Accepted commands are registered onto the memory side one cycle later;
// reads return to the issuing client two cycles after acceptance.
// Ports:
//   clk, reset               clock and asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata  packed per-client command fields
//   c_gnt                    combinational grant
//   c_rvalid, c_rdata        one-hot read valid and shared {r,g,b} read data
//   wr_*/addr_*/wdata_*      registered memory command per channel
//   rdata_*                  memory read data, one cycle after the address
module rgb_mem_arbiter
    import rgb_mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            c_req,
    input  logic [5:0]            c_we,
    input  logic [2*ADDR_W-1:0]   c_addr,
    input  logic [6*DATA_W-1:0]   c_wdata,
    output logic [1:0]            c_gnt,
    output logic [1:0]            c_rvalid,
    output logic [3*DATA_W-1:0]   c_rdata,
    output logic                  wr_r,
    output logic                  wr_g,
    output logic                  wr_b,
    output logic [ADDR_W-1:0]     addr_r,
    output logic [ADDR_W-1:0]     addr_g,
    output logic [ADDR_W-1:0]     addr_b,
    output logic [DATA_W-1:0]     wdata_r,
    output logic [DATA_W-1:0]     wdata_g,
    output logic [DATA_W-1:0]     wdata_b,
    input  logic [DATA_W-1:0]     rdata_r,
    input  logic [DATA_W-1:0]     rdata_g,
    input  logic [DATA_W-1:0]     rdata_b
);

    logic                  winner;
    logic                  hs;
    logic [2:0]            win_we;
    logic [ADDR_W-1:0]     win_addr;
    logic [3*DATA_W-1:0]   win_wdata;
    rd_tag_t               rd_s1;

    rr_arb2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (c_req),
        .gnt    (c_gnt),
        .winner (winner),
        .hs     (hs)
    );

    // Select the winning client's command fields
    always_comb begin
        case (winner)
            CLI_HOST: begin
                win_we    = c_we[5:3];
                win_addr  = c_addr[2*ADDR_W-1:ADDR_W];
                win_wdata = c_wdata[6*DATA_W-1:3*DATA_W];
            end
            default: begin
                win_we    = c_we[2:0];
                win_addr  = c_addr[ADDR_W-1:0];
                win_wdata = c_wdata[3*DATA_W-1:0];
            end
        endcase
    end

    // Memory-side issue registers; address and data hold when nothing is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_r    <= 1'b0;
            wr_g    <= 1'b0;
            wr_b    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            addr_g  <= {ADDR_W{1'b0}};
            addr_b  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            wdata_g <= {DATA_W{1'b0}};
            wdata_b <= {DATA_W{1'b0}};
        end else begin
            wr_r <= hs & win_we[CH_R];
            wr_g <= hs & win_we[CH_G];
            wr_b <= hs & win_we[CH_B];
            if (hs) begin
                addr_r  <= win_addr;
                addr_g  <= win_addr;
                addr_b  <= win_addr;
                wdata_r <= win_wdata[DATA_W*CH_R +: DATA_W];
                wdata_g <= win_wdata[DATA_W*CH_G +: DATA_W];
                wdata_b <= win_wdata[DATA_W*CH_B +: DATA_W];
            end else begin
                addr_r  <= addr_r;
                addr_g  <= addr_g;
                addr_b  <= addr_b;
                wdata_r <= wdata_r;
                wdata_g <= wdata_g;
                wdata_b <= wdata_b;
            end
        end
    end

    // Read-return tracking: stage 1 covers the memory cycle, c_rvalid is stage 2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_s1    <= '{valid: 1'b0, client: 1'b0};
            c_rvalid <= 2'b00;
        end else begin
            rd_s1.valid  <= hs && (win_we == 3'b000);
            rd_s1.client <= winner;
            c_rvalid     <= rd_s1.valid ? onehot2(rd_s1.client) : 2'b00;
        end
    end

    assign c_rdata = {rdata_r, rdata_g, rdata_b};

endmodule

// File: tb/tb_rgb_mem_arbiter.sv
// Directed bench for rgb_mem_arbiter with a behavioural memory model and a
// read-return scoreboard.
module tb_rgb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  c_req;
    logic [5:0]  c_we;
    logic [27:0] c_addr;
    logic [47:0] c_wdata;
    logic [1:0]  c_gnt;
    logic [1:0]  c_rvalid;
    logic [23:0] c_rdata;
    logic        wr_r, wr_g, wr_b;
    logic [13:0] addr_r, addr_g, addr_b;
    logic [7:0]  wdata_r, wdata_g, wdata_b;
    logic [7:0]  rdata_r, rdata_g, rdata_b;

    rgb_mem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
        .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
        .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memories, one-cycle read latency
    logic [7:0] mem_r [0:16383];
    logic [7:0] mem_g [0:16383];
    logic [7:0] mem_b [0:16383];
    always @(posedge clk) begin
        if (wr_r) mem_r[addr_r] <= wdata_r;
        if (wr_g) mem_g[addr_g] <= wdata_g;
        if (wr_b) mem_b[addr_b] <= wdata_b;
        rdata_r <= mem_r[addr_r];
        rdata_g <= mem_g[addr_g];
        rdata_b <= mem_b[addr_b];
    end

    // Reference contents, updated when the bench expects a write to be accepted
    logic [7:0] sh_r [0:16383];
    logic [7:0] sh_g [0:16383];
    logic [7:0] sh_b [0:16383];

    typedef struct {
        logic        cli;
        int          due;
        logic [23:0] data;
    } rd_exp_t;
    rd_exp_t rdq[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [2:0]  exp_wr;
    logic [13:0] exp_addr;
    logic [23:0] exp_wd;

    task automatic chk(input logic [47:0] got, input logic [47:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_cli(input int i, input logic [2:0] we, input logic [13:0] a,
                           input logic [23:0] d);
        c_we[3*i +: 3]     = we;
        c_addr[14*i +: 14] = a;
        c_wdata[24*i +: 24] = d;
    endtask

    // One clock: check grant, record expectations, then check the memory side
    task automatic step(input logic [1:0] exp_gnt, input string tag);
        logic        w;
        logic [2:0]  we;
        logic [13:0] a;
        logic [23:0] d;
        rd_exp_t     e;
        #3;
        chk({46'd0, c_gnt}, {46'd0, exp_gnt}, {tag, "_gnt"});
        if (exp_gnt != 2'b00) begin
            w  = exp_gnt[1];
            we = c_we[3*w +: 3];
            a  = c_addr[14*w +: 14];
            d  = c_wdata[24*w +: 24];
            exp_wr   = we;
            exp_addr = a;
            exp_wd   = d;
            if (we == 3'b000) begin
                e.cli  = w;
                e.due  = cyc + 2;
                e.data = {sh_r[a], sh_g[a], sh_b[a]};
                rdq.push_back(e);
            end else begin
                if (we[2]) sh_r[a] = d[23:16];
                if (we[1]) sh_g[a] = d[15:8];
                if (we[0]) sh_b[a] = d[7:0];
            end
        end else begin
            exp_wr = 3'b000;
        end
        @(posedge clk);
        cyc++;
        #1;
        chk({45'd0, wr_r, wr_g, wr_b}, {45'd0, exp_wr}, {tag, "_wr"});
        chk({6'd0, addr_r, addr_g, addr_b}, {6'd0, exp_addr, exp_addr, exp_addr}, {tag, "_addr"});
        chk({24'd0, wdata_r, wdata_g, wdata_b}, {24'd0, exp_wd}, {tag, "_wdata"});
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            e = rdq.pop_front();
            chk({46'd0, c_rvalid}, {46'd0, (e.cli ? 2'b10 : 2'b01)}, {tag, "_rvalid"});
            chk({24'd0, c_rdata}, {24'd0, e.data}, {tag, "_rdata"});
        end else begin
            chk({46'd0, c_rvalid}, 48'd0, {tag, "_no_rvalid"});
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({45'd0, wr_r, wr_g, wr_b}, 48'd0, {tag, "_wr"});
        chk({6'd0, addr_r, addr_g, addr_b}, 48'd0, {tag, "_addr"});
        chk({24'd0, wdata_r, wdata_g, wdata_b}, 48'd0, {tag, "_wdata"});
        chk({46'd0, c_rvalid}, 48'd0, {tag, "_rvalid"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        c_req    = 2'b00;
        c_we     = 6'd0;
        c_addr   = 28'd0;
        c_wdata  = 48'd0;
        exp_wr   = 3'b000;
        exp_addr = 14'd0;
        exp_wd   = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_cleared("reset");
        chk({46'd0, c_gnt}, 48'd0, "reset_gnt");
        reset = 1'b0;

        // 1: client 0 full write
        c_req = 2'b01; set_cli(0, 3'b111, 14'h0081, 24'h102030); step(2'b01, "t1_wr");
        c_req = 2'b00; step(2'b00, "t1_idle");

        // 2: client 1 reads it back
        c_req = 2'b10; set_cli(1, 3'b000, 14'h0081, 24'h000000); step(2'b10, "t2_rd");
        c_req = 2'b00; step(2'b00, "t2_wait"); step(2'b00, "t2_ret");

        // 3: both requesting continuously from idle
        set_cli(0, 3'b111, 14'h0100, 24'hA1B2C3);
        set_cli(1, 3'b000, 14'h0081, 24'h000000);
        c_req = 2'b11;
        for (int k = 0; k < 10; k++) step((((k / 4) % 2) == 1) ? 2'b10 : 2'b01, "t3_rr");
        c_req = 2'b00; step(2'b00, "t3_drain"); step(2'b00, "t3_drain");

        // 4: client 0 alone for 10 cycles, then client 1 joins
        c_req = 2'b01;
        for (int k = 0; k < 10; k++) begin
            set_cli(0, 3'b111, 14'h0200 + 14'(k), {8'(k), 8'h5A, 8'hC3});
            step(2'b01, "t4_solo");
        end
        set_cli(1, 3'b000, 14'h0100, 24'h000000);
        c_req = 2'b11; step(2'b10, "t4_switch");
        c_req = 2'b00; step(2'b00, "t4_drain"); step(2'b00, "t4_drain");

        // 5: partial write, then interleaved reads
        c_req = 2'b10; set_cli(1, 3'b100, 14'h0081, 24'h556677); step(2'b10, "t5_pwr");
        c_req = 2'b01;
        for (int k = 0; k < 3; k++) begin
            set_cli(0, 3'b111, 14'(k), {8'h40 + 8'(k), 8'h80 + 8'(k), 8'hE0 + 8'(k)});
            step(2'b01, "t5_wr");
        end
        c_req = 2'b01; set_cli(0, 3'b000, 14'h0000, 24'h0); step(2'b01, "t5_rd0");
        c_req = 2'b10; set_cli(1, 3'b000, 14'h0001, 24'h0); step(2'b10, "t5_rd1");
        c_req = 2'b01; set_cli(0, 3'b000, 14'h0002, 24'h0); step(2'b01, "t5_rd2");
        c_req = 2'b01; set_cli(0, 3'b000, 14'h0081, 24'h0); step(2'b01, "t5_rdp");
        c_req = 2'b00;
        for (int k = 0; k < 3; k++) step(2'b00, "t5_drain");

        // 6: reset right after a read handshake
        c_req = 2'b01; set_cli(0, 3'b000, 14'h0002, 24'h0); step(2'b01, "t6_rd");
        reset = 1'b1;
        c_req = 2'b00;
        #1;
        chk_cleared("t6_reset");
        rdq.delete();
        exp_wr   = 3'b000;
        exp_addr = 14'd0;
        exp_wd   = 24'd0;
        @(posedge clk);
        #1;
        chk_cleared("t6_reset_hold");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step(2'b00, "t6_post");
        set_cli(0, 3'b111, 14'h0300, 24'h0A0B0C);
        set_cli(1, 3'b111, 14'h0301, 24'h0D0E0F);
        c_req = 2'b11; step(2'b01, "t6_rearb"); step(2'b01, "t6_keep");
        c_req = 2'b00; step(2'b00, "t6_end"); step(2'b00, "t6_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
